// File: rtl/nar_mac_predictor.sv
// nar_mac_predictor: fixed-point autoregressive predictor core.
// One shared MAC walks TAPS history terms, then rounds and saturates.
module nar_mac_predictor #(
    parameter int N    = 8,
    parameter int Q    = 7,
    parameter int TAPS = 4,
    parameter int AW   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic signed [N-1:0] x_in,
    input  logic                x_ready,
    input  logic                coef_we,
    input  logic [AW-1:0]       coef_addr,
    input  logic signed [N-1:0] coef_data,
    output logic signed [N-1:0] y_out,
    output logic                out_ready,
    output logic                busy
);

    localparam int ACCW = 2*N + AW + 1;
    localparam logic [ACCW:0] HALF =
        (ACCW+1)'(1 << (Q-1));
    localparam logic signed [ACCW:0] YMAX =
        (ACCW+1)'((1 << (N-1)) - 1);
    localparam logic signed [ACCW:0] YMIN = ~YMAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic signed [N-1:0]    hist_q [TAPS];
    logic signed [N-1:0]    hist_d [TAPS];
    logic signed [N-1:0]    coef_q [TAPS];
    logic signed [N-1:0]    coef_d [TAPS];
    logic signed [N-1:0]    bias_q, bias_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic signed [N-1:0]    y_q, y_d;
    logic                   rdy_q, rdy_d;

    logic signed [N-1:0]    tap_h, tap_c;
    logic signed [2*N-1:0]  prod;
    logic signed [ACCW:0]   rnd, shf;
    logic signed [N-1:0]    y_sat;

    // select the current tap without indexing past the array end
    always_comb begin
        tap_h = '0;
        tap_c = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (idx_q == AW'(i)) begin
                tap_h = hist_q[i];
                tap_c = coef_q[i];
            end
        end
    end

    assign prod = tap_h * tap_c;

    // round half up, arithmetic shift, then clamp to Q(N,Q)
    always_comb begin
        rnd = {acc_q[ACCW-1], acc_q} + HALF;
        shf = rnd >>> Q;
        if (shf > YMAX) begin
            y_sat = YMAX[N-1:0];
        end else if (shf < YMIN) begin
            y_sat = YMIN[N-1:0];
        end else begin
            y_sat = shf[N-1:0];
        end
    end

    // next state, datapath updates and coefficient writes
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        coef_d  = coef_q;
        bias_d  = bias_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        y_d     = y_q;
        rdy_d   = 1'b0;
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (coef_we) begin
                        for (int i = 0; i < TAPS; i++) begin
                            if (coef_addr == AW'(i)) begin
                                coef_d[i] = coef_data;
                            end
                        end
                        if (coef_addr == AW'(TAPS)) begin
                            bias_d = coef_data;
                        end
                    end
                    if (x_ready) begin
                        hist_d[0] = x_in;
                        for (int i = 1; i < TAPS; i++) begin
                            hist_d[i] = hist_q[i-1];
                        end
                        acc_d = {{(ACCW-N){bias_q[N-1]}},
                                 bias_q} << Q;
                        idx_d   = '0;
                        state_d = S_MAC;
                    end
                end
                S_MAC: begin
                    acc_d = acc_q +
                        {{(ACCW-2*N){prod[2*N-1]}}, prod};
                    if (idx_q == AW'(TAPS-1)) begin
                        state_d = S_OUT;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
                S_OUT: begin
                    y_d     = y_sat;
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
            bias_q <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            y_q    <= '0;
            rdy_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            coef_q <= coef_d;
            bias_q <= bias_d;
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            y_q    <= y_d;
            rdy_q  <= rdy_d;
        end
    end

    assign y_out     = y_q;
    assign out_ready = rdy_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_nar_mac_predictor.sv
// tb_nar_mac_predictor: scoreboard bench for nar_mac_predictor.
// Expected results are queued at issue and popped on out_ready.
module tb_nar_mac_predictor;

    logic              clk;
    logic              rst;
    logic              enable;
    logic signed [7:0] x_in;
    logic              x_ready;
    logic              coef_we;
    logic [2:0]        coef_addr;
    logic signed [7:0] coef_data;
    logic signed [7:0] y_out;
    logic              out_ready;
    logic              busy;

    int total;
    int bad;
    int pulses;
    int exp_q[$];
    bit prev_rdy;

    int m_hist[4];
    int m_coef[4];
    int m_bias;

    nar_mac_predictor #(
        .N(8), .Q(7), .TAPS(4), .AW(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .x_in      (x_in),
        .x_ready   (x_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .y_out     (y_out),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        int e;
        if (out_ready) begin
            pulses++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: y_out=%0d, none pending",
                         y_out);
            end else begin
                e = exp_q.pop_front();
                if (y_out !== 8'(e)) begin
                    bad++;
                    $display("FAIL sb_y: got %0d want %0d",
                             y_out, e);
                end
            end
        end
        if (prev_rdy) begin
            total++;
            if (out_ready !== 1'b0) begin
                bad++;
                $display("FAIL pulse_width: out_ready=%b want 0",
                         out_ready);
            end
        end
        prev_rdy = out_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit hit");
        $fatal(1);
    end

    function automatic int model_y();
        int s;
        s = m_bias * 128;
        for (int i = 0; i < 4; i++) s += m_hist[i] * m_coef[i];
        s = (s + 64) >>> 7;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic do_reset(input string name);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = 0;
            m_coef[i] = 0;
        end
        m_bias = 0;
        #2;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy: got %b want 0", name, busy);
        end
        total++;
        if (out_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_rdy: got %b want 0", name, out_ready);
        end
        total++;
        if (y_out !== 8'sd0) begin
            bad++;
            $display("FAIL %s_y: got %0d want 0", name, y_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wcoef(input int addr, input int data);
        coef_addr = 3'(addr);
        coef_data = 8'(data);
        coef_we   = 1'b1;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        if (addr < 4) m_coef[addr] = data;
        else if (addr == 4) m_bias = data;
    endtask

    task automatic strobe(input int x, input int ex, input bit use_ex);
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = x;
        exp_q.push_back(use_ex ? ex : model_y());
        x_in    = 8'(x);
        x_ready = 1'b1;
        @(posedge clk);
        #1;
        x_ready = 1'b0;
    endtask

    task automatic wait_done(input int lat, input string name);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (out_ready === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || k != lat) begin
            bad++;
            $display("FAIL %s_lat: got %0d edges seen=%0d want %0d",
                     name, k, seen, lat);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: busy=%b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_basic();
        do_reset("basic_rst");
        wcoef(0, 64);
        strobe(64, 32, 1'b1);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        wait_done(5, "basic");
        @(posedge clk);
        #1;
        total++;
        if (out_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_clear: got %b want 0", out_ready);
        end
        total++;
        if (y_out !== 8'sd32) begin
            bad++;
            $display("FAIL basic_hold: got %0d want 32", y_out);
        end
    endtask

    task automatic test_rounding();
        do_reset("round_rst");
        wcoef(0, 1);
        strobe(64, 1, 1'b1);
        wait_done(5, "round_a");
        strobe(-64, 0, 1'b1);
        wait_done(5, "round_b");
        strobe(-65, -1, 1'b1);
        wait_done(5, "round_c");
    endtask

    task automatic test_delay();
        do_reset("delay_rst");
        wcoef(1, 64);
        strobe(40, 0, 1'b1);
        wait_done(5, "delay_a");
        strobe(80, 20, 1'b1);
        wait_done(5, "delay_b");
        strobe(-20, 40, 1'b1);
        wait_done(5, "delay_c");
    endtask

    task automatic test_saturation();
        do_reset("sat_rst");
        for (int a = 0; a < 4; a++) wcoef(a, 127);
        for (int n = 0; n < 3; n++) begin
            strobe(127, 0, 1'b0);
            wait_done(5, "sat_pos_ramp");
        end
        strobe(127, 127, 1'b1);
        wait_done(5, "sat_pos");
        for (int n = 0; n < 3; n++) begin
            strobe(-128, 0, 1'b0);
            wait_done(5, "sat_neg_ramp");
        end
        strobe(-128, -128, 1'b1);
        wait_done(5, "sat_neg");
        for (int a = 0; a < 4; a++) wcoef(a, 0);
        wcoef(4, 64);
        strobe(5, 64, 1'b1);
        wait_done(5, "bias_a");
        wcoef(5, 99);
        wcoef(7, -1);
        strobe(-100, 64, 1'b1);
        wait_done(5, "bias_b");
    endtask

    task automatic test_handshake();
        int p0;
        do_reset("hs_rst");
        wcoef(0, 64);
        p0 = pulses;
        strobe(64, 32, 1'b1);
        @(posedge clk);
        #1;
        x_in    = 8'sd100;
        x_ready = 1'b1;
        @(posedge clk);
        #1;
        x_ready = 1'b0;
        wait_done(3, "busy_xready");
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (pulses - p0 != 1) begin
            bad++;
            $display("FAIL busy_xready_cnt: got %0d want 1",
                     pulses - p0);
        end
        wcoef(0, 0);
        wcoef(1, 64);
        strobe(0, 0, 1'b0);
        wait_done(5, "busy_xready_hist");

        wcoef(0, 64);
        wcoef(1, 0);
        strobe(64, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || out_ready !== 1'b0) begin
            bad++;
            $display("FAIL freeze_state: busy=%b rdy=%b want 1 0",
                     busy, out_ready);
        end
        enable = 1'b1;
        wait_done(3, "freeze");

        strobe(64, 32, 1'b1);
        coef_addr = 3'd0;
        coef_data = 8'sd0;
        coef_we   = 1'b1;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        wait_done(4, "busy_write");
        strobe(64, 32, 1'b1);
        wait_done(5, "busy_write_kept");
    endtask

    task automatic test_back_to_back();
        strobe(64, 32, 1'b1);
        wait_done(5, "b2b_first");
        strobe(-64, -32, 1'b1);
        wait_done(5, "b2b_second");
    endtask

    task automatic test_reset_mid();
        int p0;
        wcoef(1, 64);
        strobe(50, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        p0 = pulses;
        do_reset("reset_mid");
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (pulses != p0) begin
            bad++;
            $display("FAIL reset_mid_pulse: got %0d pulses want 0",
                     pulses - p0);
        end
        wcoef(0, 64);
        strobe(64, 32, 1'b1);
        wait_done(5, "post_rst_a");
        wcoef(0, 0);
        wcoef(1, 64);
        wcoef(2, 64);
        wcoef(3, 64);
        strobe(0, 32, 1'b1);
        wait_done(5, "post_rst_b");
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        pulses    = 0;
        prev_rdy  = 1'b0;
        rst       = 1'b0;
        enable    = 1'b1;
        x_in      = '0;
        x_ready   = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_rounding();
        test_delay();
        test_saturation();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_left: %0d results never produced",
                     exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
